// File: rtl/hilo_div_ctrl.sv
// hilo_div_ctrl: multi-cycle restoring divider sequencer for the EX stage.
// It captures the operands on start, runs one restoring step per cycle, and
// presents {remainder, quotient} for the HI/LO write path. It holds a stall
// request while the division runs. Annul abandons the operation.
module hilo_div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_in,
    input  logic                      annul_in,
    input  logic                      signed_in,
    input  logic [DATA_WIDTH-1:0]     dividend_in,
    input  logic [DATA_WIDTH-1:0]     divisor_in,
    output logic [2*DATA_WIDTH-1:0]   result_out,
    output logic                      ready_out,
    output logic                      stall_req_out
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } state_t;

    state_t                     state_q;
    logic [CW-1:0]              cnt_q;
    logic [DATA_WIDTH-1:0]      dvd_q;      // dividend magnitude, shifted out MSB first
    logic [DATA_WIDTH-1:0]      dsr_q;      // divisor magnitude
    logic [DATA_WIDTH-1:0]      rem_q;      // partial remainder
    logic [DATA_WIDTH-1:0]      quot_q;     // quotient bits collected so far
    logic                       qneg_q;     // quotient must be negated at the end
    logic                       dneg_q;     // dividend was negative (remainder sign)
    logic [2*DATA_WIDTH-1:0]    result_q;
    logic                       ready_q;

    // Operand preparation: magnitudes and sign flags for the capture cycle
    logic                       a_neg;
    logic                       b_neg;
    logic [DATA_WIDTH-1:0]      a_mag;
    logic [DATA_WIDTH-1:0]      b_mag;

    // Restoring step datapath
    logic [DATA_WIDTH:0]        window;
    logic [DATA_WIDTH:0]        trial;
    logic                       qbit;
    logic [DATA_WIDTH-1:0]      rem_d;
    logic [DATA_WIDTH-1:0]      quot_d;
    logic [DATA_WIDTH-1:0]      quot_fix;
    logic [DATA_WIDTH-1:0]      rem_fix;

    logic                       accept;

    // Capture-time sign handling: negative signed operands become magnitudes
    always_comb begin
        a_neg = signed_in & dividend_in[DATA_WIDTH-1];
        b_neg = signed_in & divisor_in[DATA_WIDTH-1];
        a_mag = a_neg ? (DATA_WIDTH'(0) - dividend_in) : dividend_in;
        b_mag = b_neg ? (DATA_WIDTH'(0) - divisor_in)  : divisor_in;
    end

    // One restoring step. Because the partial remainder is always below the
    // divisor, the trial difference fits in DATA_WIDTH+1 bits with its MSB as sign.
    always_comb begin
        window   = {rem_q, dvd_q[DATA_WIDTH-1]};
        trial    = window - {1'b0, dsr_q};
        qbit     = ~trial[DATA_WIDTH];
        rem_d    = qbit ? trial[DATA_WIDTH-1:0] : window[DATA_WIDTH-1:0];
        quot_d   = {quot_q[DATA_WIDTH-2:0], qbit};
        quot_fix = qneg_q ? (DATA_WIDTH'(0) - quot_d) : quot_d;
        rem_fix  = dneg_q ? (DATA_WIDTH'(0) - rem_d)  : rem_d;
    end

    assign accept = start_in & ~annul_in;

    // Stall request: EX is held from the accepting cycle through the last busy cycle
    always_comb begin
        stall_req_out = 1'b0;
        case (state_q)
            IDLE:     stall_req_out = accept;
            DIV_ZERO: stall_req_out = 1'b1;
            DIV_ON:   stall_req_out = 1'b1;
            default:  stall_req_out = 1'b0;
        endcase
    end

    assign result_out = result_q;
    assign ready_out  = ready_q;

    // Sequencer FSM with registered result and ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            qneg_q   <= 1'b0;
            dneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (annul_in) begin
            // Flush wins in every state; any result is discarded.
            state_q  <= IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    result_q <= '0;
                    ready_q  <= 1'b0;
                    if (start_in) begin
                        dvd_q  <= a_mag;
                        dsr_q  <= b_mag;
                        rem_q  <= '0;
                        quot_q <= '0;
                        cnt_q  <= '0;
                        qneg_q <= a_neg ^ b_neg;
                        dneg_q <= a_neg;
                        if (divisor_in == '0) begin
                            state_q <= DIV_ZERO;
                        end else begin
                            state_q <= DIV_ON;
                        end
                    end
                end
                DIV_ZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= DIV_END;
                end
                DIV_ON: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    dvd_q  <= {dvd_q[DATA_WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        result_q <= {rem_fix, quot_fix};
                        ready_q  <= 1'b1;
                        state_q  <= DIV_END;
                    end
                end
                DIV_END: begin
                    // Result is held until EX drops its request.
                    if (!start_in) begin
                        state_q  <= IDLE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    result_q <= '0;
                    ready_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Testbench for hilo_div_ctrl: directed vector table, randomized divisions
// checked against an arithmetic reference, and annul/reset corner sequences.
module tb_hilo_div_ctrl;

    localparam int W = 32;

    logic             clk;
    logic             rst_n;
    logic             start_in;
    logic             annul_in;
    logic             signed_in;
    logic [W-1:0]     dividend_in;
    logic [W-1:0]     divisor_in;
    logic [2*W-1:0]   result_out;
    logic             ready_out;
    logic             stall_req_out;

    int n_checks;
    int n_fail;

    hilo_div_ctrl #(.DATA_WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_in      (start_in),
        .annul_in      (annul_in),
        .signed_in     (signed_in),
        .dividend_in   (dividend_in),
        .divisor_in    (divisor_in),
        .result_out    (result_out),
        .ready_out     (ready_out),
        .stall_req_out (stall_req_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [63:0]  exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic (truncating division, remainder follows dividend)
    function automatic logic [63:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, uq, ur;
        if (b == '0) return 64'd0;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        ua = {32'd0, a};
        ub = {32'd0, b};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
    endfunction

    // One complete division transaction starting from IDLE
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [63:0] exp, input string tag);
        int  lat;
        int  exp_lat;
        logic stall_ok;
        exp_lat  = (b == '0) ? 2 : 33;
        stall_ok = 1'b1;
        lat      = 99;
        @(negedge clk);
        signed_in   = s;
        dividend_in = a;
        divisor_in  = b;
        start_in    = 1'b1;
        #1;
        if (!stall_req_out) stall_ok = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            // Operands change after capture must not matter
            dividend_in = $urandom;
            divisor_in  = $urandom;
            signed_in   = ~signed_in;
            if (ready_out) begin
                lat = n;
                break;
            end
            if (!stall_req_out) stall_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " stall_window"}, {63'd0, stall_ok}, 64'd1);
        check({tag, " result"}, result_out, exp);
        check({tag, " stall_at_ready"}, {63'd0, stall_req_out}, 64'd0);
        $display("%s: signed=%0d a=0x%08h b=0x%08h result=0x%016h expected=0x%016h latency=%0d",
                 tag, s, a, b, result_out, exp, lat);
        // Result held while start stays high
        @(negedge clk);
        check({tag, " hold"}, {ready_out, result_out}, {1'b1, exp});
        start_in = 1'b0;
        @(negedge clk);
        check({tag, " release"}, {ready_out, stall_req_out, result_out}, 66'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        start_in    = 1'b0;
        annul_in    = 1'b0;
        signed_in   = 1'b0;
        dividend_in = '0;
        divisor_in  = '0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD};
        vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vecs[3]  = '{1'b0, 32'd5,          32'd0,          64'h0};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};
        vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vecs[6]  = '{1'b0, 32'd0,          32'd5,          64'h0};
        vecs[7]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
        vecs[8]  = '{1'b1, 32'hFFFFFFF8,   32'hFFFFFFFD,   64'hFFFFFFFE_00000002};
        vecs[9]  = '{1'b0, 32'd6,          32'd3,          64'h00000000_00000002};
        vecs[10] = '{1'b1, 32'hFFFFFFFB,   32'd0,          64'h0};

        repeat (3) @(negedge clk);
        check("reset_outputs", {ready_out, stall_req_out, result_out}, 66'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {ready_out, stall_req_out, result_out}, 66'd0);

        for (int i = 0; i < 11; i++) begin
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Annul during DIV_ON at cycle 10
        @(negedge clk);
        signed_in = 1'b0; dividend_in = 32'd1000; divisor_in = 32'd3; start_in = 1'b1;
        repeat (10) @(negedge clk);
        annul_in = 1'b1;
        start_in = 1'b0;
        @(negedge clk);
        check("annul_idle", {ready_out, stall_req_out, result_out}, 66'd0);
        $display("annul: ready=%0d stall=%0d", ready_out, stall_req_out);
        annul_in = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, "after_annul");

        // Reset at cycle 20 of a division
        @(negedge clk);
        signed_in = 1'b1; dividend_in = 32'hFFFF0000; divisor_in = 32'd9; start_in = 1'b1;
        repeat (20) @(negedge clk);
        rst_n    = 1'b0;
        start_in = 1'b0;
        #1;
        check("reset_mid_op", {ready_out, stall_req_out, result_out}, 66'd0);
        $display("reset mid-op: ready=%0d stall=%0d result=0x%016h", ready_out, stall_req_out, result_out);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_in = 1'b1;
        annul_in = 1'b1;
        #1;
        check("start_annul_stall", {63'd0, stall_req_out}, 64'd0);
        @(negedge clk);
        check("start_annul_idle", {ready_out, stall_req_out, result_out}, 66'd0);
        $display("start+annul: ready=%0d stall=%0d", ready_out, stall_req_out);
        start_in = 1'b0;
        annul_in = 1'b0;
        run_div(1'b1, 32'hFFFF0000, 32'd9, ref_div(1'b1, 32'hFFFF0000, 32'd9), "after_reset");

        // Randomized divisions against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            logic         s;
            logic [W-1:0] a;
            logic [W-1:0] b;
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = '0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'($urandom_range(1, 15));
                3:       b = 32'h80000000;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            run_div(s, a, b, ref_div(s, a, b), $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
